// File: rtl/mmio_interconnect.sv
// Single-master, N-slave memory-mapped interconnect with a registered request/ready
// handshake, per-transaction timeout, bus-error response and sticky error capture.
module mmio_interconnect #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h0202_0000, 32'h0201_0000, 32'h0200_0000, 32'h1000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFF0_0000},
    parameter int TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             m_req,
    input  logic                             m_we,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    input  logic [DATA_WIDTH/8-1:0]          m_be,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_ready,
    output logic                             m_err,
    output logic                             m_busy,
    output logic [NUM_SLAVES-1:0]            s_req,
    output logic                             s_we,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic [DATA_WIDTH/8-1:0]          s_be,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_ready,
    input  logic                             err_clear,
    output logic                             err_valid,
    output logic [ADDR_WIDTH-1:0]            err_addr,
    output logic [15:0]                      err_count
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    logic [SEL_W-1:0]    sel;
    logic [CNT_W-1:0]    cnt;
    logic                hit;
    logic [SEL_W-1:0]    hit_idx;
    logic                sel_ready;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                timeout;
    logic                new_err;
    logic [ADDR_WIDTH-1:0] new_err_addr;

    // Scanning downward lets the lowest matching index overwrite any higher one.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign sel_ready    = s_ready[sel];
    assign sel_rdata    = s_rdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign timeout      = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign new_err      = ((state == IDLE) && m_req && !hit) ||
                          ((state == ACCESS) && !sel_ready && timeout);
    assign new_err_addr = (state == IDLE) ? m_addr : s_addr;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            cnt     <= '0;
            s_req   <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_be    <= '0;
            m_rdata <= '0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            m_busy  <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_req) begin
                        s_we    <= m_we;
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_be    <= m_be;
                        sel     <= hit_idx;
                        cnt     <= '0;
                        m_busy  <= 1'b1;
                        if (hit) begin
                            s_req <= NUM_SLAVES'(1) << hit_idx;
                            state <= ACCESS;
                        end else begin
                            state   <= RESP;
                            m_ready <= 1'b1;
                            m_err   <= 1'b1;
                            m_rdata <= m_we ? '0 : ERR_DATA;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (sel_ready) begin
                        s_req   <= '0;
                        state   <= RESP;
                        m_ready <= 1'b1;
                        m_err   <= 1'b0;
                        m_rdata <= s_we ? '0 : sel_rdata;
                    end else if (timeout) begin
                        s_req   <= '0;
                        state   <= RESP;
                        m_ready <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= s_we ? '0 : ERR_DATA;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    m_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new error outranks a simultaneous clear and reloads the captured address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (new_err) begin
            err_valid <= 1'b1;
            if (!err_valid || err_clear)
                err_addr <= new_err_addr;
            if (err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end else if (err_clear) begin
            err_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed bench for mmio_interconnect: reads, writes, decode miss, timeout,
// error capture, back-to-back requests and mid-access reset.
module tb_mmio_interconnect;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_req, m_we;
    logic [31:0]  m_addr, m_wdata;
    logic [3:0]   m_be;
    logic [31:0]  m_rdata;
    logic         m_ready, m_err, m_busy;
    logic [3:0]   s_req;
    logic         s_we;
    logic [31:0]  s_addr, s_wdata;
    logic [3:0]   s_be;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready;
    logic         err_clear, err_valid;
    logic [31:0]  err_addr;
    logic [15:0]  err_count;

    int checks = 0;
    int errors = 0;

    mmio_interconnect dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err), .m_busy(m_busy),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .err_clear(err_clear), .err_valid(err_valid), .err_addr(err_addr),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        m_req   = 1'b1;
        m_we    = we;
        m_addr  = addr;
        m_wdata = wdata;
        m_be    = be;
    endtask

    initial begin
        int hi;
        int rdy_cyc;
        int n_rdy;
        int first_rdy;
        int last_rdy;
        int bad_req;
        int any_rdy;

        rst = 1'b1;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
        s_rdata = '0; s_ready = '0; err_clear = 1'b0;
        #2;
        check("rst_s_req", s_req, 0);
        check("rst_m_ready", m_ready, 0);
        check("rst_outputs", {m_rdata, m_err, m_busy, s_we, err_valid}, 0);
        check("rst_err", {err_addr, err_count}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Read slave 1, ready two cycles after acceptance
        issue(1'b0, 32'h0200_0004, 32'h0, 4'hF);
        step();
        m_req = 1'b0;
        check("rd1_s_req", s_req, 4'b0010);
        check("rd1_busy", m_busy, 1);
        check("rd1_s_addr", s_addr, 32'h0200_0004);
        step();
        check("rd1_no_ready_c2", m_ready, 0);
        s_rdata[32 +: 32] = 32'h1234_5678;
        s_ready = 4'b0010;
        step();
        s_ready = '0;
        check("rd1_ready_c3", m_ready, 1);
        check("rd1_rdata", m_rdata, 32'h1234_5678);
        check("rd1_err", m_err, 0);
        check("rd1_s_req_drop", s_req, 0);
        step();
        check("rd1_ready_pulse", m_ready, 0);
        check("rd1_rdata_hold", m_rdata, 32'h1234_5678);

        // Write slave 0 with immediate ready
        issue(1'b1, 32'h1000_0010, 32'hA5A5_A5A5, 4'b0011);
        step();
        m_req = 1'b0;
        check("wr_s_req", s_req, 4'b0001);
        check("wr_latch", {s_we, s_addr, s_wdata, s_be}, {1'b1, 32'h1000_0010, 32'hA5A5_A5A5, 4'b0011});
        s_ready = 4'b0001;
        step();
        s_ready = '0;
        check("wr_ready_c2", m_ready, 1);
        check("wr_err", m_err, 0);
        check("wr_rdata_zero", m_rdata, 0);
        step();

        // Decode miss
        issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        step();
        m_req = 1'b0;
        check("miss_ready_c1", m_ready, 1);
        check("miss_err", m_err, 1);
        check("miss_rdata", m_rdata, 32'hDEAD_BEEF);
        check("miss_s_req", s_req, 0);
        check("miss_err_valid", err_valid, 1);
        check("miss_err_addr", err_addr, 32'h3000_0000);
        check("miss_err_count", err_count, 1);
        step();
        check("miss_idle", m_busy, 0);

        // Slave 2 never readies: timeout
        issue(1'b0, 32'h0201_0000, 32'h0, 4'hF);
        hi = 0; rdy_cyc = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            m_req = 1'b0;
            if (m_ready) begin
                rdy_cyc = cyc;
                break;
            end
            if (s_req[2]) hi++;
        end
        check("to_s_req_cycles", hi, 16);
        check("to_ready_cycle", rdy_cyc, 17);
        check("to_err", m_err, 1);
        check("to_rdata", m_rdata, 32'hDEAD_BEEF);
        check("to_err_addr_kept", err_addr, 32'h3000_0000);
        check("to_err_count", err_count, 2);
        step();

        // Ready on the last permitted cycle wins over timeout
        issue(1'b0, 32'h0201_0020, 32'h0, 4'hF);
        s_rdata[64 +: 32] = 32'h5555_AAAA;
        hi = 0; rdy_cyc = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            m_req = 1'b0;
            s_ready = '0;
            if (m_ready) begin
                rdy_cyc = cyc;
                break;
            end
            if (s_req[2]) hi++;
            if (hi == 16) s_ready = 4'b0100;
        end
        s_ready = '0;
        check("late_ready_cycle", rdy_cyc, 17);
        check("late_err", m_err, 0);
        check("late_rdata", m_rdata, 32'h5555_AAAA);
        check("late_err_count", err_count, 2);
        step();

        // err_clear clears only err_valid
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("clr_valid", err_valid, 0);
        check("clr_count_kept", err_count, 2);

        // New error after clear reloads err_addr
        issue(1'b0, 32'h4000_0000, 32'h0, 4'hF);
        step();
        m_req = 1'b0;
        check("err2_valid", err_valid, 1);
        check("err2_addr", err_addr, 32'h4000_0000);
        check("err2_count", err_count, 3);
        step();

        // Clear coinciding with a new error: error wins with new address
        issue(1'b1, 32'h5000_0000, 32'h1, 4'hF);
        err_clear = 1'b1;
        step();
        m_req = 1'b0;
        err_clear = 1'b0;
        check("clr_err_valid", err_valid, 1);
        check("clr_err_addr", err_addr, 32'h5000_0000);
        check("clr_err_count", err_count, 4);
        check("miss_wr_rdata", m_rdata, 0);
        step();

        // Back-to-back requests, 1-cycle-ready slaves, noise on slave 3
        s_rdata[0 +: 32] = 32'h0F0F_0F0F;
        issue(1'b0, 32'h1000_0000, 32'h0, 4'hF);
        n_rdy = 0; first_rdy = -1; last_rdy = -1; bad_req = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step();
            s_ready = s_req | 4'b1000;
            if (s_req[3]) bad_req++;
            if (m_ready) begin
                if (first_rdy < 0) first_rdy = cyc;
                else check("b2b_period", cyc - last_rdy, 3);
                last_rdy = cyc;
                n_rdy++;
                check("b2b_rdata", m_rdata, 32'h0F0F_0F0F);
                check("b2b_err", m_err, 0);
            end
        end
        m_req = 1'b0;
        s_ready = '0;
        check("b2b_first", first_rdy, 2);
        check("b2b_count", n_rdy, 4);
        check("b2b_no_s3", bad_req, 0);
        step();
        check("b2b_idle", m_busy, 0);
        step();

        // Reset in the middle of an access
        issue(1'b0, 32'h0200_0000, 32'h0, 4'hF);
        step();
        m_req = 1'b0;
        check("rst_mid_pre", s_req, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_s_req", s_req, 0);
        check("rst_mid_busy", m_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        any_rdy = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            step();
            if (m_ready) any_rdy++;
        end
        check("rst_mid_no_ready", any_rdy, 0);
        check("rst_mid_idle", {m_busy, s_req}, 0);
        check("rst_mid_errcnt", err_count, 0);
        issue(1'b0, 32'h1000_0100, 32'h0, 4'hF);
        step();
        m_req = 1'b0;
        check("post_rst_s_req", s_req, 4'b0001);
        s_rdata[0 +: 32] = 32'hCAFE_F00D;
        s_ready = 4'b0001;
        step();
        s_ready = '0;
        check("post_rst_ready", m_ready, 1);
        check("post_rst_rdata", m_rdata, 32'hCAFE_F00D);
        check("post_rst_err", m_err, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
